// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, one bit per clock, LSB first,
// framed by a start/busy/done handshake. Results hold until the next DONE.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     bin,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         diff,
  output logic                     bout,
  output logic                     zero,
  output logic                     ovf,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             ai, bi, d_bit, br_nxt, accept;
  logic [WIDTH-1:0] sh_nxt;

  // Single full-subtractor cell
  assign ai     = a_q[0];
  assign bi     = b_q[0];
  assign d_bit  = ai ^ bi ^ br_q;
  assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign sh_nxt = {d_bit, sh_q[WIDTH-1:1]};
  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    sh_d    = sh_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        br_d = br_nxt;
        sh_d = sh_nxt;
        if (idx_q == LAST_IDX) begin
          // Final bit: publish results directly from the cell so they are
          // valid in the same cycle done is raised.
          state_d = DONE;
          diff_d  = sh_nxt;
          bout_d  = br_nxt;
          zero_d  = (sh_nxt == '0);
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capture is shared by IDLE and DONE (back-to-back operation)
    if (accept) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
      sh_d    = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      sh_q    <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      sh_q    <= sh_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign diff    = diff_q;
  assign bout    = bout_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;
  logic       ovf;
  logic [2:0] bit_idx;

  int n_cmp;
  int n_bad;
  int overlap_seen;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout),
    .zero   (zero),
    .ovf    (ovf),
    .bit_idx(bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_seen++;

  // Drives one operation with a one-cycle start pulse; cyc is the number of
  // edges until done is seen (0 on timeout), busy_n the busy cycles seen.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, output int cyc, output int busy_n);
    @(posedge clk); #1;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    cyc = 0; busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff got %h want 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout got %b want 0", bout); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", zero); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (bit_idx !== 3'd0) begin n_bad++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    int busy_n;
    int idx_err;
    @(posedge clk); #1;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    cyc = 0; busy_n = 0; idx_err = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
      if (busy) begin
        if (bit_idx !== 3'(busy_n)) idx_err++;
        busy_n++;
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL basic_latency got %0d want 9", cyc); end
    n_cmp++; if (busy_n !== 8) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 8", busy_n); end
    n_cmp++; if (idx_err !== 0) begin n_bad++; $display("FAIL basic_bit_idx_seq got %0d errors want 0", idx_err); end
    n_cmp++; if (diff !== 8'h02) begin n_bad++; $display("FAIL basic_diff got %h want 02", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL basic_bout got %b want 0", bout); end
    n_cmp++; if (zero !== 1'b0) begin n_bad++; $display("FAIL basic_zero got %b want 0", zero); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL basic_ovf got %b want 0", ovf); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", done); end
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vbin;
    logic [7:0] ediff;
    logic       ebout;
    logic       ezero;
    logic       eovf;
  } vec_t;

  task automatic test_vectors;
    vec_t vt[6];
    int cyc;
    int busy_n;
    vt[0] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vt[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h2A, 8'h2A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vt[5] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0};
    foreach (vt[k]) begin
      run_op(vt[k].va, vt[k].vb, vt[k].vbin, cyc, busy_n);
      n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL vec%0d_latency got %0d want 9", k, cyc); end
      n_cmp++; if (diff !== vt[k].ediff) begin n_bad++; $display("FAIL vec%0d_diff got %h want %h", k, diff, vt[k].ediff); end
      n_cmp++; if (bout !== vt[k].ebout) begin n_bad++; $display("FAIL vec%0d_bout got %b want %b", k, bout, vt[k].ebout); end
      n_cmp++; if (zero !== vt[k].ezero) begin n_bad++; $display("FAIL vec%0d_zero got %b want %b", k, zero, vt[k].ezero); end
      n_cmp++; if (ovf !== vt[k].eovf) begin n_bad++; $display("FAIL vec%0d_ovf got %b want %b", k, ovf, vt[k].eovf); end
    end
  endtask

  // Results of 0x2A-0x2A must persist through IDLE and the next RUN
  task automatic test_hold;
    int cyc;
    int busy_n;
    run_op(8'h2A, 8'h2A, 1'b0, cyc, busy_n);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (diff !== 8'h00 || zero !== 1'b1) begin n_bad++; $display("FAIL hold_idle got diff=%h zero=%b want 00/1", diff, zero); end
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy got %b want 1", busy); end
    n_cmp++; if (diff !== 8'h00 || zero !== 1'b1) begin n_bad++; $display("FAIL hold_run got diff=%h zero=%b want 00/1", diff, zero); end
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (diff !== 8'h02) begin n_bad++; $display("FAIL hold_next_diff got %h want 02", diff); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    int first_at;
    int second_at;
    int bad_diff;
    pulses = 0; first_at = 0; second_at = 0; bad_diff = 0;
    @(posedge clk); #1;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        if (diff !== 8'h02) bad_diff++;
      end
      // Operands only matter at the accepting edges 10 and 19
      if (i == 9 || i == 18) begin
        a = 8'h05; b = 8'h03; bin = 1'b0;
      end else begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      end
    end
    start = 1'b0;
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    n_cmp++; if (first_at !== 9) begin n_bad++; $display("FAIL b2b_first got %0d want 9", first_at); end
    n_cmp++; if (second_at !== 18) begin n_bad++; $display("FAIL b2b_second got %0d want 18", second_at); end
    n_cmp++; if (bad_diff !== 0) begin n_bad++; $display("FAIL b2b_diff got %0d wrong results want 0", bad_diff); end
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++; if (done !== 1'b1 || diff !== 8'h02) begin n_bad++; $display("FAIL b2b_third got done=%b diff=%h want 1/02", done, diff); end
    n_cmp++; if (overlap_seen !== 0) begin n_bad++; $display("FAIL busy_done_overlap got %0d want 0", overlap_seen); end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_run_busy got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_run_busy0 got %b want 0", busy); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL rst_run_diff got %h want 00", diff); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL rst_run_zero got %b want 1", zero); end
    n_cmp++; if (bit_idx !== 3'd0) begin n_bad++; $display("FAIL rst_run_bit_idx got %0d want 0", bit_idx); end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_run_done got %0d pulses want 0", pulses); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    overlap_seen = 0;
    test_reset();
    test_basic();
    test_vectors();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
